// File: rtl/button_command_encoder.sv
// -----------------------------------------------------------------------------
// button_command_encoder
//
// Turns up to six raw push buttons into a stream of one-byte press commands.
// Each button is synchronised, debounced and edge-detected. A press marks the
// channel pending, and pending channels drain lowest-index first into a small
// first-word-fall-through command queue.
//
// Command byte: bits[1:0] = 2'b10 and bit[2+i] = 1 for button i.
// An empty queue presents 8'h02 (null operation).
//
// Optional feature (macro BTN_AUTOREPEAT_EN):
//   A held button raises another press event every REPEAT_CYCLES cycles after
//   its first press. When the macro is undefined, no repeat logic is built.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   btn        in   raw asynchronous button levels, active-high [N_BTN]
//   cmd_ready  in   consumer ready; a command is popped when valid && ready
//   cmd_valid  out  queue not empty
//   cmd_data   out  head command byte (8'h02 when empty)
//   btn_level  out  debounced button levels [N_BTN]
//   overflow   out  sticky: a press was lost because its channel was still
//                   pending; cleared only by rst
// -----------------------------------------------------------------------------
module button_command_encoder #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 5000000,
    parameter int CNT_W           = 23,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    input  logic             cmd_ready,
    output logic             cmd_valid,
    output logic [7:0]       cmd_data,
    output logic [N_BTN-1:0] btn_level,
    output logic             overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject illegal configurations at elaboration time.
    if (N_BTN < 1 || N_BTN > 6 ||
        DEBOUNCE_CYCLES < 2 || CNT_W < 2 || CNT_W > 30 ||
        DEBOUNCE_CYCLES > (2 ** CNT_W) - 1 ||
        FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        REPEAT_CYCLES < 2) begin : g_param_check
        $error("button_command_encoder: illegal parameter set");
    end

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] r_s1;
    logic [N_BTN-1:0] r_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= btn;
            r_s2 <= r_s1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: a level change is accepted only after DEBOUNCE_CYCLES
    // consecutive mismatching samples.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt [N_BTN];
    logic [N_BTN-1:0] r_level;
    logic [N_BTN-1:0] r_level_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                r_cnt[i] <= '0;
            end
            r_level   <= '0;
            r_level_d <= '0;
        end else begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                if (r_s2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_LAST) begin
                    r_level[i] <= r_s2[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
            r_level_d <= r_level;
        end
    end

    // Only presses (0->1) produce events.
    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] w_evt;

    assign w_rise = r_level & ~r_level_d;

`ifdef BTN_AUTOREPEAT_EN
    // ------------------------------------------------------------------
    // Auto-repeat. The counter is held at zero during the press cycle
    // itself, so the first repeat lands exactly REPEAT_CYCLES after it.
    // ------------------------------------------------------------------
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0]    r_rep [N_BTN];
    logic [N_BTN-1:0] w_rep;

    always_comb begin
        w_rep = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            w_rep[i] = r_level[i] && (r_rep[i] == REP_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                r_rep[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                if (!r_level[i] || w_rise[i] || w_rep[i]) begin
                    r_rep[i] <= '0;
                end else begin
                    r_rep[i] <= r_rep[i] + 1'b1;
                end
            end
        end
    end

    assign w_evt = w_rise | w_rep;
`else
    assign w_evt = w_rise;
`endif

    // ------------------------------------------------------------------
    // Command queue (FWFT). Pointers carry an extra wrap bit.
    // ------------------------------------------------------------------
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;

    logic [N_BTN-1:0] r_pend;
    logic [N_BTN-1:0] w_sel;
    logic [N_BTN-1:0] w_clr;
    logic [7:0]       w_cmd;
    logic             r_ovf;

    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_pop   = !w_empty && cmd_ready;
    assign w_push  = (|r_pend) && (!w_full || w_pop);

    // x & -x isolates the lowest set bit, which is the one-hot channel
    // to queue; shifting it into bit 2 upward forms the command byte.
    assign w_sel = r_pend & (~r_pend + N_BTN'(1));
    assign w_cmd = 8'h02 | (8'(w_sel) << 2);
    assign w_clr = w_push ? w_sel : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            r_ovf  <= 1'b0;
            r_wp   <= '0;
            r_rp   <= '0;
        end else begin
            // An event on a still-pending channel is dropped and flagged.
            r_pend <= (r_pend & ~w_clr) | (w_evt & ~r_pend);
            r_ovf  <= r_ovf | (|(w_evt & r_pend));
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp[AW-1:0]] <= w_cmd;
        end
    end

    assign cmd_valid = !w_empty;
    assign cmd_data  = w_empty ? 8'h02 : r_mem[r_rp[AW-1:0]];
    assign btn_level = r_level;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_button_command_encoder.sv
// -----------------------------------------------------------------------------
// tb_button_command_encoder
//
// Directed bench for button_command_encoder with DEBOUNCE_CYCLES=4,
// FIFO_DEPTH=4, N_BTN=5 and REPEAT_CYCLES=10. The scenarios cover reset,
// glitch rejection, a clean press, a simultaneous press, backpressure with
// overflow, reset during debounce, and auto-repeat (only when
// BTN_AUTOREPEAT_EN is defined).
// -----------------------------------------------------------------------------
module tb_button_command_encoder;

    localparam int N_BTN = 5;
    localparam int DB    = 4;
    localparam int CW    = 4;
    localparam int FD    = 4;
    localparam int RC    = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N_BTN-1:0] btn = '0;
    logic             cmd_ready = 1'b0;
    logic             cmd_valid;
    logic [7:0]       cmd_data;
    logic [N_BTN-1:0] btn_level;
    logic             overflow;

    int         n_total = 0;
    int         n_bad   = 0;
    int         v_cnt;
    int         l_cnt;
    int         first;
    logic [7:0] p_data;
    logic [7:0] drain_exp [5];

    always #5 clk = ~clk;

    button_command_encoder #(
        .N_BTN           (N_BTN),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (CW),
        .FIFO_DEPTH      (FD),
        .REPEAT_CYCLES   (RC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .btn_level (btn_level),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past n rising edges; outputs are then sampled 1 time unit later.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        drain_exp[0] = 8'h06;
        drain_exp[1] = 8'h0A;
        drain_exp[2] = 8'h12;
        drain_exp[3] = 8'h22;
        drain_exp[4] = 8'h42;

        // Reset state
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_valid", cmd_valid, 1'b0);
        check("rst_data", cmd_data, 8'h02);
        check("rst_level", btn_level, 5'b00000);
        check("rst_ovf", overflow, 1'b0);

        // Glitch: btn[0] is high for three sampling edges only
        btn   = 5'b00001;
        v_cnt = 0;
        l_cnt = 0;
        for (int j = 0; j < 23; j++) begin
            tick(1);
            if (j == 2) btn = '0;
            if (cmd_valid) v_cnt++;
            if (btn_level != '0) l_cnt++;
        end
        check("glitch_valid_cycles", v_cnt, 0);
        check("glitch_level_cycles", l_cnt, 0);

        // Clean press of btn[1] with the consumer ready
        cmd_ready = 1'b1;
        btn       = 5'b00010;
        v_cnt     = 0;
        first     = -1;
        p_data    = '0;
        for (int j = 0; j < 20; j++) begin
            tick(1);
            if (cmd_valid) begin
                v_cnt++;
                if (first < 0) begin
                    first  = j;
                    p_data = cmd_data;
                end
            end
        end
        check("press_level_held", btn_level, 5'b00010);
        btn = '0;
        for (int j = 0; j < 15; j++) begin
            tick(1);
            if (cmd_valid) v_cnt++;
        end
        check("press_valid_cycles", v_cnt, 1);
        check("press_latency", first, 7);
        check("press_data", p_data, 8'h0A);
        check("press_level_released", btn_level, 5'b00000);

        // Simultaneous press of btn[0] and btn[4] under backpressure
        cmd_ready = 1'b0;
        btn       = 5'b10001;
        tick(10);
        check("simul_valid", cmd_valid, 1'b1);
        check("simul_head", cmd_data, 8'h06);
        tick(2);
        check("simul_head_stable", cmd_data, 8'h06);
        cmd_ready = 1'b1;
        tick(1);
        check("simul_second_valid", cmd_valid, 1'b1);
        check("simul_second_data", cmd_data, 8'h42);
        tick(1);
        check("simul_empty_valid", cmd_valid, 1'b0);
        check("simul_empty_data", cmd_data, 8'h02);
        cmd_ready = 1'b0;
        btn       = '0;
        tick(15);

        // Backpressure: five presses into a four-entry queue, then a repeat press
        btn = 5'b11111;
        tick(15);
        btn = '0;
        tick(15);
        check("bp_valid", cmd_valid, 1'b1);
        check("bp_head", cmd_data, 8'h06);
        check("bp_ovf_clear", overflow, 1'b0);
        check("bp_level", btn_level, 5'b00000);
        btn = 5'b10000;
        tick(12);
        btn = '0;
        tick(15);
        check("bp_ovf_set", overflow, 1'b1);
        cmd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("drain_valid_%0d", i), cmd_valid, 1'b1);
            check($sformatf("drain_data_%0d", i), cmd_data, drain_exp[i]);
            tick(1);
        end
        check("drain_empty", cmd_valid, 1'b0);
        check("drain_empty_data", cmd_data, 8'h02);
        check("ovf_sticky", overflow, 1'b1);
        cmd_ready = 1'b0;
        tick(3);

        // Reset clears the sticky flag; then reset lands mid-debounce
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_ovf_cleared", overflow, 1'b0);
        btn = 5'b00100;
        tick(4);
        rst = 1'b1;
        btn = '0;
        tick(1);
        rst   = 1'b0;
        v_cnt = 0;
        l_cnt = 0;
        for (int j = 0; j < 20; j++) begin
            tick(1);
            if (cmd_valid) v_cnt++;
            if (btn_level != '0) l_cnt++;
        end
        check("midrst_valid_cycles", v_cnt, 0);
        check("midrst_level_cycles", l_cnt, 0);
        check("midrst_valid", cmd_valid, 1'b0);
        check("midrst_data", cmd_data, 8'h02);

`ifdef BTN_AUTOREPEAT_EN
        // Auto-repeat: btn[3] is held for 40 sampling edges with the consumer ready
        cmd_ready = 1'b1;
        btn       = 5'b01000;
        v_cnt     = 0;
        for (int j = 0; j < 70; j++) begin
            tick(1);
            if (j == 39) btn = '0;
            if (cmd_valid) begin
                check($sformatf("rep_time_%0d", v_cnt), j, 7 + 10 * v_cnt);
                check($sformatf("rep_data_%0d", v_cnt), cmd_data, 8'h22);
                v_cnt++;
            end
        end
        check("rep_count", v_cnt, 4);
        cmd_ready = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
